// File: rtl/fft16_pkg.sv
// Shared constants, state encoding, twiddle codes and butterfly address helper for the
// 16-point radix-2 DIT FFT sequencer (optional IFFT conjugation: FFT_BF_SCHED_INVERSE_EN).
package fft16_pkg;

  localparam int unsigned N_PTS    = 16;
  localparam int unsigned N_STAGES = 4;
  localparam int unsigned N_BF     = 8;
  localparam int unsigned ADDR_W   = $clog2(N_PTS);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Q1.7 codes of W16^k, k = 0..7
  localparam logic [7:0] TW_RE [0:7] = '{
    8'h7F, 8'h76, 8'h5A, 8'h31, 8'h00, 8'hCF, 8'hA6, 8'h8A
  };
  localparam logic [7:0] TW_IM [0:7] = '{
    8'h00, 8'hCF, 8'hA6, 8'h8A, 8'h81, 8'h8A, 8'hA6, 8'hCF
  };

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [2:0]        k;
  } bf_addr_t;

  // Operand pair and twiddle index of butterfly j within stage s.
  function automatic bf_addr_t bf_addr_calc(input logic [1:0] s, input logic [2:0] j);
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] grp;
    logic [ADDR_W-1:0] pos;
    bf_addr_t          r;
    span = ADDR_W'(1) << s;
    grp  = {1'b0, j} >> s;
    pos  = {1'b0, j} & (span - ADDR_W'(1));
    r.a  = (grp << ({1'b0, s} + 3'd1)) | pos;
    r.b  = r.a + span;
    r.k  = 3'(pos << (3'd3 - {1'b0, s}));
    return r;
  endfunction

endpackage

// File: rtl/fft16_tw_rom.sv
// Twiddle code lookup for the butterfly constant multipliers.
// With FFT_BF_SCHED_INVERSE_EN, inv selects the conjugate (negated imaginary) code.
module fft16_tw_rom
  import fft16_pkg::*;
(
  input  logic [2:0] k,
`ifdef FFT_BF_SCHED_INVERSE_EN
  input  logic       inv,
`endif
  output logic [7:0] tw_re,
  output logic [7:0] tw_im
);

  always_comb begin
    tw_re = TW_RE[k];
    tw_im = TW_IM[k];
`ifdef FFT_BF_SCHED_INVERSE_EN
    if (inv) begin
      tw_im = 8'(~TW_IM[k] + 8'd1);
    end
`endif
  end

endmodule

// File: rtl/fft16_bf_sched.sv
// Butterfly issue sequencer for an in-place 16-point radix-2 DIT FFT with a per-stage
// write-back barrier. Define FFT_BF_SCHED_INVERSE_EN to add the inv (IFFT) input.
module fft16_bf_sched
  import fft16_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef FFT_BF_SCHED_INVERSE_EN
  input  logic       inv,
`endif
  output logic       busy,
  output logic       done,
  output logic       bf_valid,
  input  logic       bf_ready,
  output logic [3:0] bf_addr_a,
  output logic [3:0] bf_addr_b,
  output logic [1:0] bf_stage,
  output logic [2:0] tw_k,
  output logic [7:0] tw_re,
  output logic [7:0] tw_im,
  input  logic       wb_valid,
  output logic       wb_err
);

  localparam logic [3:0] MaxOut = 4'(MAX_INFLIGHT);

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] j_q, j_d;          // butterflies loaded into the issue register this stage
  logic [3:0] outst_q, outst_d;
  logic [3:0] wb_cnt_q, wb_cnt_d;
  logic       wb_err_q, wb_err_d;
  logic       valid_q, valid_d;
  logic [3:0] addr_a_q, addr_b_q;
  logic [1:0] stage_out_q;
  logic [2:0] k_q;
  logic [7:0] re_q, im_q;
  logic       fire, wb_ok, load;
  bf_addr_t   nxt;
  logic [7:0] rom_re, rom_im;
`ifdef FFT_BF_SCHED_INVERSE_EN
  logic       inv_q, inv_d;
`endif

  assign nxt = bf_addr_calc(stage_q, j_q[2:0]);

  fft16_tw_rom u_tw_rom (
    .k     (nxt.k),
`ifdef FFT_BF_SCHED_INVERSE_EN
    .inv   (inv_q),
`endif
    .tw_re (rom_re),
    .tw_im (rom_im)
  );

  always_comb begin
    fire     = valid_q && bf_ready;
    wb_ok    = wb_valid && (outst_q != '0);
    outst_d  = outst_q + {3'b000, fire} - {3'b000, wb_ok};
    state_d  = state_q;
    stage_d  = stage_q;
    j_d      = j_q;
    wb_cnt_d = wb_cnt_q + {3'b000, wb_ok};
    wb_err_d = wb_err_q || (wb_valid && (outst_q == '0));
    valid_d  = valid_q && !fire;
    load     = 1'b0;
`ifdef FFT_BF_SCHED_INVERSE_EN
    inv_d    = inv_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StIssue;
          stage_d  = '0;
          j_d      = '0;
          outst_d  = '0;
          wb_cnt_d = '0;
          wb_err_d = wb_valid && (outst_q == '0);
`ifdef FFT_BF_SCHED_INVERSE_EN
          inv_d    = inv;
`endif
        end
      end
      StIssue: begin
        // Refill the issue register only if the slot frees up and the in-flight cap allows it.
        if ((!valid_q || fire) && (j_q != 4'(N_BF)) && (outst_d < MaxOut)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          j_d     = j_q + 4'd1;
        end
        if (fire && (j_q == 4'(N_BF))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (wb_cnt_q == 4'(N_BF)) begin
          if (stage_q == 2'(N_STAGES - 1)) begin
            state_d = StDone;
          end else begin
            state_d  = StIssue;
            stage_d  = stage_q + 2'd1;
            j_d      = '0;
            wb_cnt_d = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      stage_q     <= '0;
      j_q         <= '0;
      outst_q     <= '0;
      wb_cnt_q    <= '0;
      wb_err_q    <= 1'b0;
      valid_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      stage_out_q <= '0;
      k_q         <= '0;
      re_q        <= '0;
      im_q        <= '0;
`ifdef FFT_BF_SCHED_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      j_q      <= j_d;
      outst_q  <= outst_d;
      wb_cnt_q <= wb_cnt_d;
      wb_err_q <= wb_err_d;
      valid_q  <= valid_d;
`ifdef FFT_BF_SCHED_INVERSE_EN
      inv_q    <= inv_d;
`endif
      if (load) begin
        addr_a_q    <= nxt.a;
        addr_b_q    <= nxt.b;
        stage_out_q <= stage_q;
        k_q         <= nxt.k;
        re_q        <= rom_re;
        im_q        <= rom_im;
      end
    end
  end

  assign busy      = (state_q == StIssue) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign bf_valid  = valid_q;
  assign bf_addr_a = addr_a_q;
  assign bf_addr_b = addr_b_q;
  assign bf_stage  = stage_out_q;
  assign tw_k      = k_q;
  assign tw_re     = re_q;
  assign tw_im     = im_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_fft16_bf_sched.sv
// Bench for fft16_bf_sched: two instances (MAX_INFLIGHT 8 and 2) checked every cycle against
// a butterfly-order/in-flight model; define FFT_BF_SCHED_INVERSE_EN to cover the inv path.
module tb_fft16_bf_sched;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, bf_ready, wb_valid;
  wire  [1:0] busy, done, bf_valid, wb_err;
  wire  [3:0] addr_a [2];
  wire  [3:0] addr_b [2];
  wire  [1:0] stg [2];
  wire  [2:0] kk [2];
  wire  [7:0] twr [2];
  wire  [7:0] twi [2];
  logic inv_in;

  always #5 clk = ~clk;

  fft16_bf_sched #(.MAX_INFLIGHT(8)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
`ifdef FFT_BF_SCHED_INVERSE_EN
    .inv(inv_in),
`endif
    .busy(busy[0]), .done(done[0]), .bf_valid(bf_valid[0]), .bf_ready(bf_ready[0]),
    .bf_addr_a(addr_a[0]), .bf_addr_b(addr_b[0]), .bf_stage(stg[0]), .tw_k(kk[0]),
    .tw_re(twr[0]), .tw_im(twi[0]), .wb_valid(wb_valid[0]), .wb_err(wb_err[0])
  );

  fft16_bf_sched #(.MAX_INFLIGHT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
`ifdef FFT_BF_SCHED_INVERSE_EN
    .inv(inv_in),
`endif
    .busy(busy[1]), .done(done[1]), .bf_valid(bf_valid[1]), .bf_ready(bf_ready[1]),
    .bf_addr_a(addr_a[1]), .bf_addr_b(addr_b[1]), .bf_stage(stg[1]), .tw_k(kk[1]),
    .tw_re(twr[1]), .tw_im(twi[1]), .wb_valid(wb_valid[1]), .wb_err(wb_err[1])
  );

  int checks = 0;
  int errors = 0;

  // Expected issue order and twiddle tables
  int ea [32], eb [32], ek [32], es [32];
  logic [7:0] tre [8], tim [8];

  // Bench configuration (main process) and model state (compare process)
  int lat [2], rmode [2], inj_req [2], inj_done [2];
  int fires [2], wbs [2], outst [2], wbsent [2], done_cnt [2];
  int due [2][32];
  logic run [2], eerr [2], hold [2], inv_lat [2], maxed [2];
  int cyc = 0;
  logic [3:0] la [32], lb [32];
  logic [2:0] lk [32];
  logic [7:0] lre [32], lim [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int max_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_busy", busy[i], 0);
        chk("rst_done", done[i], 0);
        chk("rst_valid", bf_valid[i], 0);
        chk("rst_payload", {addr_a[i], addr_b[i], stg[i], kk[i], twr[i], twi[i]}, 0);
        chk("rst_wb_err", wb_err[i], 0);
        run[i] = 0; fires[i] = 0; wbs[i] = 0; outst[i] = 0; wbsent[i] = 0;
        eerr[i] = 0; hold[i] = 0;
        inj_done[i] = inj_req[i];
        bf_ready[i] = 1'b0;
        wb_valid[i] = 1'b0;
      end else begin
        logic jd, wbv, inj, fire, acc;
        int f;
        jd = 1'b0;
        f = fires[i];
        chk("wb_err", wb_err[i], eerr[i]);
        if (done[i]) begin
          chk("done_while_running", run[i], 1);
          chk("done_issues", fires[i], 32);
          chk("done_writebacks", wbs[i], 32);
          chk("busy_in_done", busy[i], 0);
          chk("valid_in_done", bf_valid[i], 0);
          run[i] = 0;
          jd = 1'b1;
          done_cnt[i]++;
        end else if (run[i]) begin
          chk("busy_running", busy[i], 1);
        end else begin
          chk("busy_idle", busy[i], 0);
          chk("valid_idle", bf_valid[i], 0);
        end
        if (hold[i]) chk("valid_withdrawn", bf_valid[i], 1);
        if (bf_valid[i]) begin
          if (f < 32) begin
            chk("bf_stage", stg[i], es[f]);
            chk("bf_addr_a", addr_a[i], ea[f]);
            chk("bf_addr_b", addr_b[i], eb[f]);
            chk("tw_k", kk[i], ek[f]);
            chk("tw_re", twr[i], tre[ek[f]]);
            chk("tw_im", twi[i], inv_lat[i] ? 8'(8'h00 - tim[ek[f]]) : tim[ek[f]]);
            chk("inflight_limit", outst[i] < max_of(i), 1);
            chk("stage_barrier", wbs[i] >= 8 * es[f], 1);
          end else begin
            chk("valid_after_32", bf_valid[i], 0);
          end
        end
        // drive inputs for the next rising edge
        bf_ready[i] = (rmode[i] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        wbv = (wbsent[i] < fires[i]) && (due[i][wbsent[i]] <= cyc);
        inj = (inj_req[i] != inj_done[i]);
        inj_done[i] = inj_req[i];
        wb_valid[i] = wbv || inj;
        if (wbv) wbsent[i]++;
        // model the effect of that edge
        fire = bf_valid[i] && bf_ready[i];
        acc = start[i] && !run[i] && !jd;
        if (acc) begin
          run[i] = 1; fires[i] = 0; wbs[i] = 0; wbsent[i] = 0; eerr[i] = 0;
          inv_lat[i] = inv_in;
        end
        if (wb_valid[i]) begin
          if (outst[i] > 0) begin
            outst[i]--;
            wbs[i]++;
          end else begin
            eerr[i] = 1;
          end
        end
        if (fire && fires[i] < 32) begin
          if (i == 0) begin
            la[f] = addr_a[i]; lb[f] = addr_b[i]; lk[f] = kk[i];
            lre[f] = twr[i]; lim[f] = twi[i];
          end
          due[i][f] = cyc + lat[i];
          fires[i]++;
          outst[i]++;
          if (outst[i] == max_of(i)) maxed[i] = 1;
        end
        hold[i] = bf_valid[i] && !bf_ready[i];
      end
    end
  end

  task automatic run_fft(input int i, input bit poke);
    int d0, n;
    d0 = done_cnt[i];
    @(posedge clk); #2 start[i] = 1'b1;
    @(posedge clk); #2 start[i] = 1'b0;
    chk("busy_after_start", busy[i], 1);
    chk("wb_err_after_start", wb_err[i], 0);
    chk("valid_latency_0", bf_valid[i], 0);
    @(posedge clk); #2 chk("valid_latency_1", bf_valid[i], 1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #2 start[i] = 1'b1;
      @(posedge clk); #2 start[i] = 1'b0;
    end
    n = 0;
    while (done_cnt[i] == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt[i] - d0, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int idx, n;
    idx = 0;
    for (int s = 0; s < 4; s++) begin
      for (int g = 0; g < 16; g += 2 * (1 << s)) begin
        for (int p = 0; p < (1 << s); p++) begin
          ea[idx] = g + p; eb[idx] = g + p + (1 << s);
          ek[idx] = p * 8 / (1 << s); es[idx] = s;
          idx++;
        end
      end
    end
    tre = '{8'h7F, 8'h76, 8'h5A, 8'h31, 8'h00, 8'hCF, 8'hA6, 8'h8A};
    tim = '{8'h00, 8'hCF, 8'hA6, 8'h8A, 8'h81, 8'h8A, 8'hA6, 8'hCF};
    for (int i = 0; i < 2; i++) begin
      inj_req[i] = 0; done_cnt[i] = 0; maxed[i] = 0; inv_lat[i] = 0;
    end
    lat = '{2, 5};
    rmode = '{0, 1};
    inv_in = 1'b0;
    start = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Full run, always ready, write-back 2 cycles after issue
    run_fft(0, 1'b0);
    chk("pin0_pair", {la[0], lb[0], 1'b0, lk[0]}, {4'd0, 4'd1, 4'd0});
    chk("pin7_pair", {la[7], lb[7]}, {4'd14, 4'd15});
    chk("pin9_pair", {la[9], lb[9], 1'b0, lk[9]}, {4'd1, 4'd3, 4'd4});
    chk("pin9_tw", {lre[9], lim[9]}, 16'h0081);
    chk("pin24_pair", {la[24], lb[24]}, {4'd0, 4'd8});
    chk("pin24_tw", {lre[24], lim[24]}, 16'h7F00);
    chk("pin29_pair", {la[29], lb[29], 1'b0, lk[29]}, {4'd5, 4'd13, 4'd5});
    chk("pin29_tw", {lre[29], lim[29]}, 16'hCF8A);
    chk("pin31_tw", {la[31], lb[31], lre[31], lim[31]}, {4'd7, 4'd15, 16'h8ACF});

    // In-flight cap of 2, slow write-backs, random backpressure
    run_fft(1, 1'b0);
    chk("cap_reached", maxed[1], 1);

    // Random backpressure on the wide instance
    rmode[0] = 1;
    run_fft(0, 1'b0);
    rmode[0] = 0;

    // Spurious write-back in IDLE, then a run with a start poke mid-issue
    @(posedge clk); #2 inj_req[0]++;
    repeat (3) @(posedge clk);
    #2 chk("wb_err_sticky", wb_err[0], 1);
    run_fft(0, 1'b1);

    // Asynchronous reset in the middle of stage 2, then a clean rerun
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    n = 0;
    while (fires[0] < 18 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("reached_stage2", fires[0] >= 18, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_valid", bf_valid[0], 0);
    chk("async_rst_payload", {addr_a[0], addr_b[0], stg[0], kk[0], twr[0], twi[0]}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_fft(0, 1'b0);

`ifdef FFT_BF_SCHED_INVERSE_EN
    inv_in = 1'b1;
    run_fft(0, 1'b0);
    inv_in = 1'b0;
    chk("inv_j4_tw", {lre[28], lim[28]}, 16'h007F);
    chk("inv_j1_tw", {lre[25], lim[25]}, 16'h7631);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
